// File: rtl/regfile_pkg.sv
// Shared register-file constants and RISC-V major opcodes used by the mux, decode and scoreboard.
package regfile_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int CNTW = 6;
    localparam int NREG = 1 << AW;

    typedef enum logic [6:0] {
        OP_R = 7'b0110011,
        OP_I = 7'b0010011,
        OP_S = 7'b0100011,
        OP_U = 7'b0110111,
        OP_B = 7'b1100011,
        OP_J = 7'b1101111
    } opcode_e;

endpackage

// File: rtl/regfile_array.sv
// 2^AW x XLEN register storage: two combinational read ports, one synchronous write port, x0 masked.
module regfile_array
    import regfile_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   i_ra1,
    input  logic [AW-1:0]   i_ra2,
    output logic [XLEN-1:0] o_rd1,
    output logic [XLEN-1:0] o_rd2,
    input  logic            i_we,
    input  logic [AW-1:0]   i_wa,
    input  logic [XLEN-1:0] i_wd
);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];

    always_comb begin
        mem_d = mem_q;
        if (i_we && (i_wa != '0)) begin
            mem_d[i_wa] = i_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign o_rd1 = (i_ra1 == '0) ? '0 : mem_q[i_ra1];
    assign o_rd2 = (i_ra2 == '0) ? '0 : mem_q[i_ra2];

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy scoreboard, reservation counter and sticky write-back error.
// Optional macro REGFILE_WB_BYPASS_EN forwards same-cycle write-back data and releases its hazard.
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic [AW-1:0]   i_RS1,
    input  logic [AW-1:0]   i_RS2,
    output logic [XLEN-1:0] o_REG_OUT1,
    output logic [XLEN-1:0] o_REG_OUT2,
    input  logic            i_ISSUE_VALID,
    input  logic [AW-1:0]   i_ISSUE_RD,
    input  logic            i_ISSUE_WR,
    input  logic            i_ISSUE_USE_RS1,
    input  logic            i_ISSUE_USE_RS2,
    output logic            o_ISSUE_READY,
    input  logic            i_WB_VALID,
    input  logic [AW-1:0]   i_WB_RD,
    input  logic [XLEN-1:0] i_WB_DATA,
    output logic [CNTW-1:0] o_BUSY_CNT,
    output logic            o_SB_ERR
);

    // Issue handshake: fires on a rising edge where i_ISSUE_VALID && o_ISSUE_READY;
    // READY never depends on VALID, and write-back has no ready (always accepted).

    logic [XLEN-1:0] arr_rd1, arr_rd2;
    logic [NREG-1:0] busy_q, busy_d, busy_eff;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            wb_hit, issue_fire, cnt_inc, cnt_dec;

    assign wb_hit = i_WB_VALID && (i_WB_RD != '0);

    regfile_array u_array (
        .clk   (CLK),
        .rst   (RST),
        .i_ra1 (i_RS1),
        .i_ra2 (i_RS2),
        .o_rd1 (arr_rd1),
        .o_rd2 (arr_rd2),
        .i_we  (wb_hit),
        .i_wa  (i_WB_RD),
        .i_wd  (i_WB_DATA)
    );

`ifdef REGFILE_WB_BYPASS_EN
    always_comb begin
        busy_eff = busy_q;
        if (wb_hit) begin
            busy_eff[i_WB_RD] = 1'b0;
        end
        o_REG_OUT1 = (wb_hit && (i_WB_RD == i_RS1)) ? i_WB_DATA : arr_rd1;
        o_REG_OUT2 = (wb_hit && (i_WB_RD == i_RS2)) ? i_WB_DATA : arr_rd2;
    end
`else
    assign busy_eff   = busy_q;
    assign o_REG_OUT1 = arr_rd1;
    assign o_REG_OUT2 = arr_rd2;
`endif

    assign o_ISSUE_READY = !(i_ISSUE_USE_RS1 && busy_eff[i_RS1])
                        && !(i_ISSUE_USE_RS2 && busy_eff[i_RS2])
                        && !(i_ISSUE_WR      && busy_eff[i_ISSUE_RD]);

    assign issue_fire = i_ISSUE_VALID && o_ISSUE_READY && i_ISSUE_WR && (i_ISSUE_RD != '0);

    // Counter tracks popcount(busy): a release of the register being re-reserved is a no-op.
    assign cnt_inc = issue_fire && !busy_q[i_ISSUE_RD];
    assign cnt_dec = wb_hit && busy_q[i_WB_RD] && !(issue_fire && (i_ISSUE_RD == i_WB_RD));

    always_comb begin
        busy_d = busy_q;
        if (wb_hit) begin
            busy_d[i_WB_RD] = 1'b0;
        end
        if (issue_fire) begin
            busy_d[i_ISSUE_RD] = 1'b1;
        end
        busy_d[0] = 1'b0;

        cnt_d = cnt_q;
        if (cnt_inc && !cnt_dec) begin
            cnt_d = cnt_q + CNTW'(1);
        end else if (cnt_dec && !cnt_inc) begin
            cnt_d = cnt_q - CNTW'(1);
        end

        err_d = err_q || (wb_hit && !busy_q[i_WB_RD]);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign o_BUSY_CNT = cnt_q;
    assign o_SB_ERR   = err_q;

endmodule
